// File: rtl/pipe_rca.sv
// pipe_rca -- pipelined ripple-carry adder/subtractor.
//
// The WIDTH-bit operands are split into SEG-bit segments; stage k resolves
// segment k and registers its carry for stage k+1, so the carry chain in any
// one cycle is only SEG bits long. Operand segments not yet consumed travel in
// skew registers, and finished partial sums travel in deskew registers, so a
// whole result leaves the last stage at once. Latency is STAGES = WIDTH/SEG
// cycles, and throughput is one beat per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   block accepts an input beat this cycle
//   in_a       operand A
//   in_b       operand B
//   in_cin     carry-in (ignored when in_sub=1)
//   in_sub     1: A - B, computed as A + ~B + 1
//   out_valid  result beat valid
//   out_ready  downstream accepts the result
//   out_sum    result
//   out_cout   carry-out of the MSB (for subtract, 1 = no borrow)
//   out_ovf    signed overflow; present only when PIPE_RCA_OVF_EN is defined
//
// Optional feature macro: PIPE_RCA_OVF_EN adds out_ovf.

module pipe_rca #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef PIPE_RCA_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int STAGES = WIDTH / SEG;

    function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] a,
                                             input logic [SEG-1:0] b,
                                             input logic           c);
        return {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, c};
    endfunction

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // Stage inputs: stage 0 takes the port values, stage k takes stage k-1's registers.
    logic [WIDTH-1:0] a_cur [STAGES];
    logic [WIDTH-1:0] b_cur [STAGES];
    logic [WIDTH-1:0] s_cur [STAGES];
    logic             c_cur [STAGES];
    logic             v_cur [STAGES];

    // Values each stage will register.
    logic [WIDTH-1:0] nsum  [STAGES];
    logic             ncar  [STAGES];

    // Pipeline registers, one set per stage.
    logic [WIDTH-1:0] a_p   [STAGES];
    logic [WIDTH-1:0] b_p   [STAGES];
    logic [WIDTH-1:0] sum_p [STAGES];
    logic             c_p   [STAGES];
    logic             vld_p [STAGES];

    // The whole pipeline moves together; it freezes only when the output
    // holds a result that downstream has not taken.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign b_eff = in_sub ? ~in_b : in_b;
    assign c0    = in_sub ? 1'b1 : in_cin;

    always_comb begin
        logic [SEG:0] res;
        res = '0;
        a_cur[0] = in_a;
        b_cur[0] = b_eff;
        s_cur[0] = '0;
        c_cur[0] = c0;
        v_cur[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_cur[k] = a_p[k-1];
            b_cur[k] = b_p[k-1];
            s_cur[k] = sum_p[k-1];
            c_cur[k] = c_p[k-1];
            v_cur[k] = vld_p[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            res = seg_add(a_cur[k][k*SEG +: SEG], b_cur[k][k*SEG +: SEG], c_cur[k]);
            nsum[k] = s_cur[k];
            nsum[k][k*SEG +: SEG] = res[SEG-1:0];
            ncar[k] = res[SEG];
        end
    end

    // ---- stage registers (segment k resolved into stage k) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_p[k] <= 1'b0;
                a_p[k]   <= '0;
                b_p[k]   <= '0;
                sum_p[k] <= '0;
                c_p[k]   <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_p[k] <= v_cur[k];
                a_p[k]   <= a_cur[k];
                b_p[k]   <= b_cur[k];
                sum_p[k] <= nsum[k];
                c_p[k]   <= ncar[k];
            end
        end
    end

    assign out_valid = vld_p[STAGES-1];
    assign out_sum   = sum_p[STAGES-1];
    assign out_cout  = c_p[STAGES-1];

`ifdef PIPE_RCA_OVF_EN
    logic ovf_p;
    logic msb_cin;

    // Carry into the MSB is recovered from a ^ b ^ sum at that bit.
    assign msb_cin = a_cur[STAGES-1][WIDTH-1] ^ b_cur[STAGES-1][WIDTH-1]
                   ^ nsum[STAGES-1][WIDTH-1];

    // ---- overflow register, aligned with the last stage ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_p <= 1'b0;
        end else if (adv) begin
            ovf_p <= msb_cin ^ ncar[STAGES-1];
        end
    end

    assign out_ovf = ovf_p;
`endif

endmodule

// File: tb/tb_pipe_rca.sv
module tb_pipe_rca;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_cin;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_cout;
`ifdef PIPE_RCA_OVF_EN
    logic        out_ovf;
`endif

    int tests = 0;
    int fails = 0;

    pipe_rca #(.WIDTH(16), .SEG(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
`ifdef PIPE_RCA_OVF_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; leaves the pipeline empty at posedge+1.
    task automatic apply(input vec_t v);
        int lat;
        in_valid  = 1'b1;
        in_a      = v.a;
        in_b      = v.b;
        in_cin    = v.cin;
        in_sub    = v.sub;
        out_ready = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 10);
        chk({v.name, " latency"}, 32'(lat), 32'd4);
        chk({v.name, " sum"}, 32'(out_sum), 32'(v.sum));
        chk({v.name, " cout"}, 32'(out_cout), 32'(v.cout));
`ifdef PIPE_RCA_OVF_EN
        chk({v.name, " ovf"}, 32'(out_ovf), 32'(v.ovf));
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{"add_1234_0fcd", 16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0};
        vecs[1] = '{"carry_all_segs", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{"sub_5_7",        16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3] = '{"sub_8000_1",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[4] = '{"add_7fff_1",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[5] = '{"sub_cin_ignored",16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{"add_0f0f_00f1",  16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[7] = '{"add_ffff_ffff_c",16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[8] = '{"add_8000_8000",  16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_sum", 32'(out_sum), 32'd0);
        chk("reset out_cout", 32'(out_cout), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            apply(vecs[i]);
        end

        // Back-to-back stream of a=i, b=i with out_ready low in cycles 6-8.
        begin
            int sent;
            int rcv;
            bit was_stalled;
            logic [15:0] held_sum;
            bit acc;
            bit take;
            sent = 0;
            rcv = 0;
            was_stalled = 0;
            held_sum = '0;
            in_cin = 1'b0;
            in_sub = 1'b0;
            for (int t = 0; t < 40 && rcv < 10; t++) begin
                out_ready = !(t >= 6 && t <= 8);
                in_valid  = (sent < 10);
                in_a      = 16'(sent);
                in_b      = 16'(sent);
                #1;
                chk($sformatf("stream in_ready t=%0d", t), 32'(in_ready),
                    32'(!(out_valid && !out_ready)));
                if (out_valid && !out_ready) begin
                    if (was_stalled)
                        chk($sformatf("stream hold t=%0d", t), 32'(out_sum), 32'(held_sum));
                    held_sum = out_sum;
                    was_stalled = 1;
                end else begin
                    was_stalled = 0;
                end
                acc  = in_valid && in_ready;
                take = out_valid && out_ready;
                if (take) begin
                    chk($sformatf("stream out %0d", rcv), 32'(out_sum), 32'(2 * rcv));
                    rcv++;
                end
                @(posedge clk);
                #1;
                if (acc) sent++;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            chk("stream beats received", 32'(rcv), 32'd10);
            @(posedge clk);
            #1;
            chk("stream drained", 32'(out_valid), 32'd0);
        end

        // Bubble preservation: beats in cycles 0 and 2 only.
        out_ready = 1'b1;
        in_sub    = 1'b0;
        in_cin    = 1'b0;
        for (int t = 0; t < 10; t++) begin
            in_valid = (t == 0 || t == 2);
            in_a     = (t == 0) ? 16'h0100 : 16'h0200;
            in_b     = (t == 0) ? 16'h0001 : 16'h0002;
            #1;
            chk($sformatf("bubble out_valid t=%0d", t), 32'(out_valid), 32'(t == 4 || t == 6));
            if (t == 4) chk("bubble sum beat0", 32'(out_sum), 32'h0101);
            if (t == 6) chk("bubble sum beat1", 32'(out_sum), 32'h0202);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;

        // Reset mid-flight: 3 beats in, reset before any emerges.
        for (int t = 0; t < 3; t++) begin
            in_valid = 1'b1;
            in_a     = 16'(t + 1);
            in_b     = 16'h0000;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midreset out_valid", 32'(out_valid), 32'd0);
        chk("midreset in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int t = 0; t < 8; t++) begin
            @(posedge clk);
            #1;
            chk($sformatf("after reset idle t=%0d", t), 32'(out_valid), 32'd0);
        end
        apply(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
